// File: rtl/sram_arb_pkg.sv
// Shared sizing and state encoding for the two-port SRAM arbiter/controller.
package sram_arb_pkg;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned WIDTH = 48;
    localparam int unsigned SEGS  = 8;
    localparam int unsigned AW    = 9;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester always wins; on contention
// the pointer picks (0 = p0, 1 = p1).
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (&valid_i) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter in front of a single-port masked-write SRAM; clears the whole
// array after reset before accepting any request.
module sram_arb_ctrl
    import sram_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    output logic             init_done,
    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic             p0_req_write,
    input  logic [AW-1:0]    p0_req_addr,
    input  logic [SEGS-1:0]  p0_req_wmask,
    input  logic [WIDTH-1:0] p0_req_wdata,
    output logic             p0_resp_valid,
    output logic [WIDTH-1:0] p0_resp_rdata,
    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic             p1_req_write,
    input  logic [AW-1:0]    p1_req_addr,
    input  logic [SEGS-1:0]  p1_req_wmask,
    input  logic [WIDTH-1:0] p1_req_wdata,
    output logic             p1_resp_valid,
    output logic [WIDTH-1:0] p1_resp_rdata,
    output logic             mem_en,
    output logic             mem_wmode,
    output logic [AW-1:0]    mem_addr,
    output logic [SEGS-1:0]  mem_wmask,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic             init_done_q, init_done_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             in_run;
    logic [1:0]       req_valid;
    logic [1:0]       grant;

    assign in_run    = (state_q == StRun);
    assign req_valid = {p1_req_valid, p0_req_valid} & {2{in_run}};

    rr_arb2 u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];
    assign init_done    = init_done_q;

    // SRAM data arrives in the response cycle; pass it straight through, then hold it.
    assign p0_resp_valid = resp_valid_q[0];
    assign p1_resp_valid = resp_valid_q[1];
    assign p0_resp_rdata = resp_valid_q[0] ? mem_rdata : rdata0_q;
    assign p1_resp_rdata = resp_valid_q[1] ? mem_rdata : rdata1_q;

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = cnt_q;
        mem_wmask = '1;
        mem_wdata = '0;
        if (!in_run) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
        end else if (grant[1]) begin
            mem_en    = 1'b1;
            mem_wmode = p1_req_write;
            mem_addr  = p1_req_addr;
            mem_wmask = p1_req_wmask;
            mem_wdata = p1_req_wdata;
        end else if (grant[0]) begin
            mem_en    = 1'b1;
            mem_wmode = p0_req_write;
            mem_addr  = p0_req_addr;
            mem_wmask = p0_req_wmask;
            mem_wdata = p0_req_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        init_done_d  = init_done_q;
        resp_valid_d = 2'b00;
        rdata0_d     = resp_valid_q[0] ? mem_rdata : rdata0_q;
        rdata1_d     = resp_valid_q[1] ? mem_rdata : rdata1_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d     = StRun;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                if (|grant) begin
                    ptr_d = grant[0];
                end
                resp_valid_d = grant & {~p1_req_write, ~p0_req_write};
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            ptr_q        <= 1'b0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= resp_valid_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH 512, entry count; WIDTH 48, data bits; SEGS 8, write-mask segments of WIDTH/SEGS = 6 bits; AW 9, address bits (log2 DEPTH).
REQ-002 Ports SHALL be, with clock and reset first; pN denotes ports p0 and p1:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once memory clear completes
- pN_req_valid  in  1  request present
- pN_req_ready  out  1  request accepted this cycle
- pN_req_write  in  1  1 = masked write, 0 = read
- pN_req_addr  in  AW  entry address
- pN_req_wmask  in  SEGS  per-segment write enable
- pN_req_wdata  in  WIDTH  write data
- pN_resp_valid  out  1  read data valid (no backpressure)
- pN_resp_rdata  out  WIDTH  read data
- mem_en  out  1  SRAM access enable
- mem_wmode  out  1  SRAM write select
- mem_addr  out  AW  SRAM address
- mem_wmask  out  SEGS  SRAM segment mask
- mem_wdata  out  WIDTH  SRAM write data
- mem_rdata  in  WIDTH  SRAM read data, valid 1 cycle after a read enable

Function
REQ-003 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-004 INIT SHALL drive one write per cycle: mem_en=1, mem_wmode=1, mem_wmask all ones, mem_wdata=0, mem_addr = init counter 0..DEPTH-1.
REQ-005 INIT SHALL transition to RUN on the cycle after the write to address DEPTH-1; init_done SHALL be registered and SHALL rise in the first RUN cycle.
REQ-006 In INIT, both pN_req_ready SHALL be 0.
REQ-007 RUN SHALL grant at most one request per cycle; pN_req_ready SHALL be combinational from the valids and the priority pointer, and SHALL NOT depend on ready.
REQ-008 If one port is valid, that port SHALL be granted; if both are valid, the port named by the pointer SHALL be granted.
REQ-009 After any grant, the pointer SHALL move to the non-granted port; with no grant, it SHALL hold. Its reset value SHALL be p0.
REQ-010 On a grant: mem_en=1, mem_wmode = req_write, and mem_addr/mem_wmask/mem_wdata = the granted port's fields, same cycle.
REQ-011 A granted read SHALL assert that port's pN_resp_valid exactly one cycle later, for one cycle, with pN_resp_rdata = mem_rdata.
REQ-012 Writes SHALL produce no response.
REQ-013 With no grant, mem_en SHALL be 0.
REQ-014 While resp_valid is low, pN_resp_rdata SHALL hold its last value.
REQ-015 A read granted in the cycle after a write to the same address SHALL return the written data (the SRAM's natural ordering); no bypass logic.
REQ-016 A request with wmask=0 and write=1 SHALL still be granted and consume a cycle.
REQ-017 Sustained throughput SHALL be one access per cycle; with both ports continuously valid, grants SHALL strictly alternate.

Reset
REQ-018 reset_n low SHALL asynchronously clear: FSM to INIT, init counter 0, pointer p0, init_done 0, both resp_valid 0, resp_rdata 0.
REQ-019 Assertion mid-INIT or mid-RUN SHALL drop any pending read response and restart the full clear sequence.

Structure
REQ-020 DEPTH, WIDTH, SEGS, AW and the FSM state enum SHALL reside in shared package sram_arb_pkg.
REQ-021 The round-robin grant logic SHALL be the sub-module rr_arb2 (inputs: two valids, pointer; outputs: one-hot grant). All other logic stays in the top level.

Verification
REQ-022 Reset release -> exactly 512 zero writes at addresses 0..511 with mask 0xFF; init_done high on cycle 513; no ready during INIT.
REQ-023 p0 writes 0xABCDEF012345 to addr 5 with mask 0x0F, then reads addr 5 -> p0_resp_rdata = 0x000000012345, one cycle after the read grant.
REQ-024 p0 and p1 continuously valid reads for 6 cycles -> grants p0,p1,p0,p1,p0,p1; each resp_valid lands on the matching port.
REQ-025 p1 writes 0x3F to addr 511 with mask 0x01; the next cycle p0 reads addr 511 -> p0 receives 0x00000000003F.
REQ-026 Reset asserted on the cycle after a read grant -> no resp_valid; the clear sequence restarts at address 0.
